// File: rtl/stereo_moving_avg.sv
// Stereo boxcar (moving-average) low-pass filter for the codec sample path.
// Each channel keeps a ring of the last 2^LOG2_DEPTH samples and a running
// sum of those samples. On every read_ready the oldest ring entry is swapped
// out for the new sample, and the sum is adjusted by the difference. Both
// channels share one write pointer and one arithmetic path shape, but their
// data never mixes.
//
// Strobe semantics: read_ready is a valid-only strobe with no back-pressure.
// Every cycle in which it is high (and reset is low) one sample pair is
// accepted. out_valid is its registered copy: it is high in the cycle after
// the accepting edge, the same cycle that out_left/out_right carry the new
// result. If read_ready is held high, out_valid stays high.
module stereo_moving_avg #(
    parameter int DATA_W     = 24,
    parameter int LOG2_DEPTH = 3
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              bypass,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE = 1;

    logic [DATA_W-1:0]        r_ring_l [DEPTH];
    logic [DATA_W-1:0]        r_ring_r [DEPTH];
    logic signed [SUM_W-1:0]  r_sum_l;
    logic signed [SUM_W-1:0]  r_sum_r;
    logic [LOG2_DEPTH-1:0]    r_ptr;

    logic signed [SUM_W-1:0]  w_in_l_sext;
    logic signed [SUM_W-1:0]  w_in_r_sext;
    logic signed [SUM_W-1:0]  w_old_l_sext;
    logic signed [SUM_W-1:0]  w_old_r_sext;
    logic signed [SUM_W-1:0]  w_sum_l_next;
    logic signed [SUM_W-1:0]  w_sum_r_next;
    logic [DATA_W-1:0]        w_avg_l;
    logic [DATA_W-1:0]        w_avg_r;

    // Next running sums: add the incoming sample, drop the one it overwrites.
    // Taking bits [SUM_W-1:LOG2_DEPTH] of the signed sum is exactly an
    // arithmetic right shift by LOG2_DEPTH (floor toward -inf) truncated to
    // DATA_W bits; the mean of DATA_W-bit values always fits in DATA_W bits.
    always_comb begin
        w_in_l_sext  = {{LOG2_DEPTH{in_left[DATA_W-1]}},  in_left};
        w_in_r_sext  = {{LOG2_DEPTH{in_right[DATA_W-1]}}, in_right};
        w_old_l_sext = {{LOG2_DEPTH{r_ring_l[r_ptr][DATA_W-1]}}, r_ring_l[r_ptr]};
        w_old_r_sext = {{LOG2_DEPTH{r_ring_r[r_ptr][DATA_W-1]}}, r_ring_r[r_ptr]};
        w_sum_l_next = r_sum_l + w_in_l_sext - w_old_l_sext;
        w_sum_r_next = r_sum_r + w_in_r_sext - w_old_r_sext;
        w_avg_l      = w_sum_l_next[SUM_W-1:LOG2_DEPTH];
        w_avg_r      = w_sum_r_next[SUM_W-1:LOG2_DEPTH];
    end

    // History, sums and pointer: cleared by reset, advanced on each strobe,
    // held otherwise. Bypass does not stop the history from being updated, so
    // leaving bypass yields the true window average at once.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ring_l[i] <= '0;
                r_ring_r[i] <= '0;
            end
            r_sum_l <= '0;
            r_sum_r <= '0;
            r_ptr   <= '0;
        end else if (read_ready) begin
            r_ring_l[r_ptr] <= in_left;
            r_ring_r[r_ptr] <= in_right;
            r_sum_l         <= w_sum_l_next;
            r_sum_r         <= w_sum_r_next;
            r_ptr           <= r_ptr + PTR_ONE;
        end
    end

    // Output registers: filtered or bypassed sample on each strobe, hold when
    // idle; out_valid is a registered copy of an accepted strobe.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= read_ready;
            if (read_ready) begin
                out_left  <= bypass ? in_left  : w_avg_l;
                out_right <= bypass ? in_right : w_avg_r;
            end
        end
    end

endmodule

// File: tb/tb_stereo_moving_avg.sv
// Directed bench for stereo_moving_avg. Two instances share one stimulus
// bus: the default-depth filter (N=8) and a short one (N=4). Expected values
// are worked out by hand from the boxcar definition.
module tb_stereo_moving_avg;

    localparam int W = 24;

    logic          clk;
    logic          reset;
    logic          read_ready;
    logic [W-1:0]  in_left;
    logic [W-1:0]  in_right;
    logic          bypass;

    logic [W-1:0]  out_left8, out_right8;
    logic          out_valid8;
    logic [W-1:0]  out_left4, out_right4;
    logic          out_valid4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    stereo_moving_avg #(.DATA_W(W), .LOG2_DEPTH(3)) dut8 (
        .CLOCK_50   (clk),
        .reset      (reset),
        .read_ready (read_ready),
        .in_left    (in_left),
        .in_right   (in_right),
        .bypass     (bypass),
        .out_left   (out_left8),
        .out_right  (out_right8),
        .out_valid  (out_valid8)
    );

    stereo_moving_avg #(.DATA_W(W), .LOG2_DEPTH(2)) dut4 (
        .CLOCK_50   (clk),
        .reset      (reset),
        .read_ready (read_ready),
        .in_left    (in_left),
        .in_right   (in_right),
        .bypass     (bypass),
        .out_left   (out_left4),
        .out_right  (out_right4),
        .out_valid  (out_valid4)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the rising edge take them, then sample
    // outputs 1 time unit later.
    task automatic step(input logic rr, input logic [W-1:0] l,
                        input logic [W-1:0] r, input logic byp);
        read_ready = rr;
        in_left    = l;
        in_right   = r;
        bypass     = byp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rr);
        reset = 1'b1;
        step(rr, 24'd0, 24'd0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [W-1:0] e;
        longint       lf;

        reset = 1'b1; read_ready = 1'b0; in_left = '0; in_right = '0; bypass = 1'b0;

        // Reset state
        do_reset(1'b1);
        check("rst_left8",  out_left8,  24'd0);
        check("rst_right8", out_right8, 24'd0);
        check_bit("rst_valid8", out_valid8, 1'b0);
        check_bit("rst_valid4", out_valid4, 1'b0);

        // 1. N=4 left stream, read_ready held high
        exp_q = '{24'd2, 24'd6, 24'd8, 24'd16, 24'd16, 24'd16};
        foreach (exp_q[i]) begin end
        begin
            logic [W-1:0] stim[6];
            stim = '{24'd8, 24'd16, 24'd8, 24'd32, 24'd8, 24'd16};
            for (int i = 0; i < 6; i++) begin
                step(1'b1, stim[i], 24'd0, 1'b0);
                e = exp_q.pop_front();
                check($sformatf("t1_left4_%0d", i), out_left4, e);
                check_bit($sformatf("t1_valid4_%0d", i), out_valid4, 1'b1);
            end
        end
        step(1'b0, 24'd0, 24'd0, 1'b0);
        check_bit("t1_valid_drop", out_valid4, 1'b0);
        check("t1_hold", out_left4, 24'd16);

        // 2. N=8, right constant -8: outputs -1, -2, ... -8, then stay -8
        do_reset(1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 24'd0, 24'hFFFFF8, 1'b0);
            e = (i >= 8) ? 24'hFFFFF8 : -(W'(i));
            check($sformatf("t2_right8_%0d", i), out_right8, e);
        end
        check("t2_left_untouched", out_left8, 24'd0);

        // 3. Strobe every third cycle, left=24: mean after k strobes is 3k
        do_reset(1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 24'd24, 24'd0, 1'b0);
            check_bit($sformatf("t3_valid_%0d", k), out_valid8, 1'b1);
            check($sformatf("t3_left_%0d", k), out_left8, W'(3 * k));
            step(1'b0, 24'd99, 24'd99, 1'b0);
            check_bit($sformatf("t3_gap_valid_%0d", k), out_valid8, 1'b0);
            step(1'b0, 24'd77, 24'd77, 1'b1);
            check($sformatf("t3_gap_hold_%0d", k), out_left8, W'(3 * k));
        end

        // 4. Bypass: fill with 16, bypass 100 and 0, then filtered 16.
        // Window afterwards: five 16s, 100, 0, 16 -> 196/8 = 24 (floor).
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 24'd16, 24'd16, 1'b0);
        check("t4_filled", out_left8, 24'd16);
        step(1'b1, 24'd100, 24'd100, 1'b1);
        check("t4_byp_100_l", out_left8, 24'd100);
        check("t4_byp_100_r", out_right8, 24'd100);
        step(1'b1, 24'd0, 24'd0, 1'b1);
        check("t4_byp_0", out_left8, 24'd0);
        step(1'b1, 24'd16, 24'd16, 1'b0);
        check("t4_after_byp_l", out_left8, 24'd24);
        check("t4_after_byp_r", out_right8, 24'd24);

        // 5. Reset mid-stream with read_ready high
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 24'd40, 24'd40, 1'b0);
        check("t5_before", out_left8, 24'd25);
        reset = 1'b1;
        step(1'b1, 24'd40, 24'd40, 1'b0);
        reset = 1'b0;
        check("t5_rst_left", out_left8, 24'd0);
        check("t5_rst_right", out_right8, 24'd0);
        check_bit("t5_rst_valid", out_valid8, 1'b0);
        step(1'b1, 24'd40, 24'd40, 1'b0);
        check("t5_first_left", out_left8, 24'd5);
        check("t5_first_right", out_right8, 24'd5);

        // 6. Full scale: left max positive, right max negative
        do_reset(1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 24'h7FFFFF, 24'h800000, 1'b0);
            lf = (longint'(k) * 64'd8388607) >> 3;
            check($sformatf("t6_left_%0d", k), out_left8, W'(lf));
            check($sformatf("t6_right_%0d", k), out_right8, -(W'(k) << 20));
        end
        step(1'b1, 24'h7FFFFF, 24'h800000, 1'b0);
        check("t6_steady_left", out_left8, 24'h7FFFFF);
        check("t6_steady_right", out_right8, 24'h800000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
